// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch stage. Owns the program counter, presents it to a
//   combinational instruction memory, and loads the fetched word into the IF/ID
//   pipeline register. A four-state controller (BOOT, RUN, HALT, ERR) handles
//   stalls, taken branches/jumps, the halt instruction and misaligned targets.
//
// Ports
//   clk_i              rising-edge clock
//   rst_i              synchronous active-high reset
//   imem_addr_o        byte address to instruction memory (always the PC)
//   imem_clear_o       forces memory read data to zero outside RUN
//   imem_inst_i        combinational read data for imem_addr_o
//   stall_i            hold PC and IF/ID
//   redirect_valid_i   taken branch/jump: flush IF/ID and load redirect_target_i
//   redirect_target_i  new PC, used only when redirect_valid_i is set
//   if_id_pc_o         PC of the instruction in IF/ID
//   if_id_inst_o       instruction in IF/ID
//   if_id_valid_o      IF/ID holds a real instruction (0 = bubble)
//   halted_o           fetch stopped (HALT or ERR)
//   misalign_err_o     sticky flag: a redirect target was not word aligned
//   fetch_count_o      instructions loaded into IF/ID since reset (wraps)
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'h0010_0073
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] imem_addr_o,
  output logic        imem_clear_o,
  input  logic [31:0] imem_inst_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_inst_o,
  output logic        if_id_valid_o,
  output logic        halted_o,
  output logic        misalign_err_o,
  output logic [31:0] fetch_count_o
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  // A target is usable only if it lands on a 32-bit instruction boundary.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

  state_e      state_q,        state_d;
  logic [31:0] pc_q,           pc_d;
  logic [31:0] if_id_pc_q,     if_id_pc_d;
  logic [31:0] if_id_inst_q,   if_id_inst_d;
  logic        if_id_valid_q,  if_id_valid_d;
  logic [31:0] fetch_count_q,  fetch_count_d;
  logic        misalign_q,     misalign_d;
  logic        halted_q,       halted_d;
  logic        imem_clear_q,   imem_clear_d;

  // Next-state and datapath decisions for one cycle.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = misalign_q;

    case (state_q)
      ST_BOOT: begin
        // One settling cycle: memory is still cleared, nothing is loaded.
        state_d = ST_RUN;
      end

      ST_RUN, ST_HALT: begin
        if (redirect_valid_i) begin
          // Redirect wins over stall and halt detection; the wrong-path
          // instruction in IF/ID is squashed either way.
          if_id_pc_d    = 32'h0000_0000;
          if_id_inst_d  = 32'h0000_0000;
          if_id_valid_d = 1'b0;
          if (is_word_aligned(redirect_target_i[1:0])) begin
            pc_d    = redirect_target_i;
            state_d = ST_RUN;
          end else begin
            misalign_d = 1'b1;
            state_d    = ST_ERR;
          end
        end else if (state_q == ST_HALT) begin
          // The halt instruction stays visible for exactly one unstalled cycle.
          if (!stall_i) begin
            if_id_valid_d = 1'b0;
          end else begin
            if_id_valid_d = if_id_valid_q;
          end
        end else if (stall_i) begin
          state_d = ST_RUN;
        end else begin
          if_id_pc_d    = pc_q;
          if_id_inst_d  = imem_inst_i;
          if_id_valid_d = 1'b1;
          fetch_count_d = fetch_count_q + 32'd1;
          // The halt word is delivered downstream but the PC parks on it.
          if (imem_inst_i == HALT_INST) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = pc_q + 32'd4;
            state_d = ST_RUN;
          end
        end
      end

      ST_ERR: begin
        // Terminal: only reset leaves this state.
        if_id_valid_d = 1'b0;
        state_d       = ST_ERR;
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state register itself.
    halted_d     = (state_d == ST_HALT) || (state_d == ST_ERR);
    imem_clear_d = (state_d != ST_RUN);
  end

  // State and pipeline register update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      if_id_pc_q    <= 32'h0000_0000;
      if_id_inst_q  <= 32'h0000_0000;
      if_id_valid_q <= 1'b0;
      fetch_count_q <= 32'h0000_0000;
      misalign_q    <= 1'b0;
      halted_q      <= 1'b0;
      imem_clear_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
      fetch_count_q <= fetch_count_d;
      misalign_q    <= misalign_d;
      halted_q      <= halted_d;
      imem_clear_q  <= imem_clear_d;
    end
  end

  assign imem_addr_o    = pc_q;
  assign imem_clear_o   = imem_clear_q;
  assign if_id_pc_o     = if_id_pc_q;
  assign if_id_inst_o   = if_id_inst_q;
  assign if_id_valid_o  = if_id_valid_q;
  assign halted_o       = halted_q;
  assign misalign_err_o = misalign_q;
  assign fetch_count_o  = fetch_count_q;

  inst_fetch_chk u_chk (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .halted_i       (halted_q),
    .imem_clear_i   (imem_clear_q),
    .misalign_err_i (misalign_q)
  );

endmodule

// -----------------------------------------------------------------------------
// inst_fetch_chk
//   Property checker for inst_fetch status outputs.
//
// Ports
//   clk_i, rst_i     clock and synchronous reset of the checked block
//   halted_i         halted output
//   imem_clear_i     memory clear output
//   misalign_err_i   sticky misalignment flag
// -----------------------------------------------------------------------------
module inst_fetch_chk (
  input logic clk_i,
  input logic rst_i,
  input logic halted_i,
  input logic imem_clear_i,
  input logic misalign_err_i
);

  // A stopped fetch unit must never let memory data through.
  a_halt_clears : assert property (@(posedge clk_i) disable iff (rst_i)
    halted_i |-> imem_clear_i);

  // A misaligned redirect always leaves fetch stopped.
  a_err_halts : assert property (@(posedge clk_i) disable iff (rst_i)
    misalign_err_i |-> halted_i);

  // The error flag only clears through reset.
  a_err_sticky : assert property (@(posedge clk_i) disable iff (rst_i)
    misalign_err_i |=> misalign_err_i);

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] HALT_WORD = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst, stall, rv;
  logic [31:0] rt;
  logic [31:0] mem [0:255];

  logic [31:0] imem_addr, imem_inst, ipc, iinst, cnt;
  logic        imem_clear, ivalid, halted, mis;

  logic [31:0] w_addr, w_inst, w_ipc, w_iinst, w_cnt;
  logic        w_clear, w_valid, w_halted, w_mis;

  int nvec = 0;
  int nmis = 0;
  logic mon_en = 1'b0;

  // behavioural model state
  logic [31:0] m_pc, m_ipc, m_iinst, m_cnt;
  logic        m_iv, m_boot, m_halt, m_err;

  always #5 clk = ~clk;

  assign imem_inst = imem_clear ? 32'h0000_0000 : mem[imem_addr[9:2]];
  assign w_inst    = w_clear    ? 32'h0000_0000 : mem[w_addr[9:2]];

  inst_fetch dut (
    .clk_i(clk), .rst_i(rst), .imem_addr_o(imem_addr), .imem_clear_o(imem_clear),
    .imem_inst_i(imem_inst), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_target_i(rt), .if_id_pc_o(ipc), .if_id_inst_o(iinst),
    .if_id_valid_o(ivalid), .halted_o(halted), .misalign_err_o(mis),
    .fetch_count_o(cnt)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk_i(clk), .rst_i(rst), .imem_addr_o(w_addr), .imem_clear_o(w_clear),
    .imem_inst_i(w_inst), .stall_i(1'b0), .redirect_valid_i(1'b0),
    .redirect_target_i(32'h0000_0000), .if_id_pc_o(w_ipc), .if_id_inst_o(w_iinst),
    .if_id_valid_o(w_valid), .halted_o(w_halted), .misalign_err_o(w_mis),
    .fetch_count_o(w_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the fetch stage must do this cycle, by priority.
  always @(posedge clk) begin
    if (rst) begin
      m_pc <= 32'h0000_0000; m_ipc <= 32'h0; m_iinst <= 32'h0; m_iv <= 1'b0;
      m_cnt <= 32'h0; m_boot <= 1'b1; m_halt <= 1'b0; m_err <= 1'b0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_err) begin
      m_iv <= 1'b0;
    end else if (rv) begin
      m_ipc <= 32'h0; m_iinst <= 32'h0; m_iv <= 1'b0; m_halt <= 1'b0;
      if (rt[1:0] == 2'b00) m_pc <= rt;
      else m_err <= 1'b1;
    end else if (m_halt) begin
      if (!stall) m_iv <= 1'b0;
    end else if (!stall) begin
      m_ipc <= m_pc; m_iinst <= mem[m_pc[9:2]]; m_iv <= 1'b1; m_cnt <= m_cnt + 32'd1;
      if (mem[m_pc[9:2]] == HALT_WORD) m_halt <= 1'b1;
      else m_pc <= m_pc + 32'd4;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      check("imem_addr", imem_addr, m_pc);
      check("imem_clear", {31'd0, imem_clear}, {31'd0, m_boot | m_halt | m_err});
      check("if_id_pc", ipc, m_ipc);
      check("if_id_inst", iinst, m_iinst);
      check("if_id_valid", {31'd0, ivalid}, {31'd0, m_iv});
      check("halted", {31'd0, halted}, {31'd0, m_halt | m_err});
      check("misalign_err", {31'd0, mis}, {31'd0, m_err});
      check("fetch_count", cnt, m_cnt);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[255] = 32'hBEEF_0013;
    rst = 1'b1; stall = 1'b0; rv = 1'b0; rt = 32'h0;
    @(negedge clk); @(negedge clk);
    mon_en = 1'b1;
    check("rst_valid", {31'd0, ivalid}, 32'd0);
    check("rst_count", cnt, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_clear", {31'd0, imem_clear}, 32'd1);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    @(negedge clk);  // BOOT cycle done
    check("boot_clear", {31'd0, imem_clear}, 32'd0);
    check("boot_noload", {31'd0, ivalid}, 32'd0);
    @(negedge clk);
    check("f0_pc", ipc, 32'h0);
    check("f0_inst", iinst, 32'hA000_0000);
    check("wrap_addr", w_addr, 32'h0000_0000);
    check("wrap_ifpc", w_ipc, 32'hFFFF_FFFC);
    check("wrap_inst", w_iinst, 32'hBEEF_0013);
    check("wrap_cnt", w_cnt, 32'd1);
    @(negedge clk);
    check("f1_pc", ipc, 32'h4);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    check("stall_ifpc", ipc, 32'h4);
    check("stall_pc", imem_addr, 32'h8);
    check("stall_cnt", cnt, 32'd2);
    stall = 1'b0;
    @(negedge clk);
    check("rel_ifpc", ipc, 32'h8);
    check("rel_inst", iinst, 32'hA000_0002);
    check("rel_cnt", cnt, 32'd3);
    @(negedge clk);
    check("pc10", imem_addr, 32'h10);
    stall = 1'b1; rv = 1'b1; rt = 32'h40;
    @(negedge clk);
    check("redir_bubble", {31'd0, ivalid}, 32'd0);
    check("redir_addr", imem_addr, 32'h40);
    rv = 1'b0; stall = 1'b0; rt = 32'hDEAD_BEE1;
    @(negedge clk);
    check("redir_fetch_pc", ipc, 32'h40);
    check("redir_fetch_inst", iinst, 32'hA000_0010);
    check("redir_cnt", cnt, 32'd5);
    // halt instruction at 0x0C
    mem[3] = HALT_WORD; rv = 1'b1; rt = 32'h4;
    @(negedge clk);
    rv = 1'b0;
    repeat (3) @(negedge clk);
    check("halt_inst", iinst, HALT_WORD);
    check("halt_valid", {31'd0, ivalid}, 32'd1);
    check("halt_addr", imem_addr, 32'hC);
    check("halt_cnt", cnt, 32'd8);
    stall = 1'b1;
    @(negedge clk);
    check("halt_stall_hold", {31'd0, ivalid}, 32'd1);
    stall = 1'b0;
    @(negedge clk);
    check("halt_drain", {31'd0, ivalid}, 32'd0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_clear", {31'd0, imem_clear}, 32'd1);
    @(negedge clk);
    rv = 1'b1; rt = 32'h20;
    @(negedge clk);
    rv = 1'b0;
    check("unhalt", {31'd0, halted}, 32'd0);
    check("unhalt_addr", imem_addr, 32'h20);
    @(negedge clk);
    check("unhalt_fetch", ipc, 32'h20);
    check("unhalt_inst", iinst, 32'hA000_0008);
    // misaligned redirect
    rv = 1'b1; rt = 32'h22;
    @(negedge clk);
    check("mis_flag", {31'd0, mis}, 32'd1);
    check("mis_halted", {31'd0, halted}, 32'd1);
    check("mis_pc", imem_addr, 32'h24);
    rt = 32'h40;
    @(negedge clk);
    check("err_ignore", imem_addr, 32'h24);
    rv = 1'b0; stall = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1; rv = 1'b1; rt = 32'h80;
    @(negedge clk);
    check("err_rst_mis", {31'd0, mis}, 32'd0);
    check("err_rst_pc", imem_addr, 32'h0);
    check("err_rst_clear", {31'd0, imem_clear}, 32'd1);
    rst = 1'b0; rv = 1'b0; stall = 1'b0;
    mem[3] = 32'hA000_0003;
    for (int i = 0; i < 40; i++) begin
      stall = (i % 5 == 2);
      rv = (i % 11 == 7);
      rt = 32'h0000_0100 + i * 4;
      @(negedge clk);
    end
    rv = 1'b0; stall = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("stall_rst_pc", imem_addr, 32'h0);
    rst = 1'b0; stall = 1'b0;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
